// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the memory-stage bundle, extracts loads,
// and drives the register-file write port plus a retired-instruction count.
module mem_wb_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [DW-1:0]   ReadData,
    input  logic [DW-1:0]   Result,
    input  logic [RW-1:0]   WriteReg,
    input  logic            RegWrite,
    input  logic            MemtoReg,
    input  logic [2:0]      LoadType,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic [RW-1:0]   wb_reg,
    output logic [DW-1:0]   wb_data,
    output logic            align_err,
    output logic [CNTW-1:0] retired
);

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic            validQ;
    logic            regWriteQ;
    logic            memToRegQ;
    logic [RW-1:0]   writeRegQ;
    logic [2:0]      loadTypeQ;
    logic [DW-1:0]   resultQ;
    logic [DW-1:0]   readDataQ;
    logic            alignErrQ;
    logic [CNTW-1:0] retiredQ;

    logic inHalf;
    logic inByte;
    logic misalign;

    always_comb begin
        inHalf = (LoadType == LT_LH) || (LoadType == LT_LHU);
        inByte = (LoadType == LT_LB) || (LoadType == LT_LBU);
        misalign = valid_in && RegWrite && MemtoReg &&
                   ((!inHalf && !inByte && (Result[1:0] != 2'b00)) ||
                    (inHalf && Result[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ    <= 1'b0;
            regWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            writeRegQ <= '0;
            loadTypeQ <= '0;
            resultQ   <= '0;
            readDataQ <= '0;
            alignErrQ <= 1'b0;
            retiredQ  <= '0;
        end else if (flush) begin
            validQ    <= 1'b0;
            regWriteQ <= 1'b0;
            memToRegQ <= MemtoReg;
            writeRegQ <= WriteReg;
            loadTypeQ <= LoadType;
            resultQ   <= Result;
            readDataQ <= ReadData;
            alignErrQ <= 1'b0;
        end else if (!stall) begin
            validQ    <= valid_in;
            regWriteQ <= RegWrite;
            memToRegQ <= MemtoReg;
            writeRegQ <= WriteReg;
            loadTypeQ <= LoadType;
            resultQ   <= Result;
            readDataQ <= ReadData;
            alignErrQ <= misalign;
            if (valid_in) begin
                retiredQ <= retiredQ + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    logic [7:0]    byteVal;
    logic [15:0]   halfVal;
    logic [DW-1:0] loadVal;

    // Big-endian lane selection: address 0 is the most significant byte.
    always_comb begin
        byteVal = readDataQ[7:0];
        case (resultQ[1:0])
            2'b00:   byteVal = readDataQ[31:24];
            2'b01:   byteVal = readDataQ[23:16];
            2'b10:   byteVal = readDataQ[15:8];
            default: byteVal = readDataQ[7:0];
        endcase
        halfVal = resultQ[1] ? readDataQ[15:0] : readDataQ[31:16];
        loadVal = readDataQ;
        unique case (1'b1)
            (loadTypeQ == LT_LB):  loadVal = {{24{byteVal[7]}}, byteVal};
            (loadTypeQ == LT_LBU): loadVal = {24'd0, byteVal};
            (loadTypeQ == LT_LH):  loadVal = {{16{halfVal[15]}}, halfVal};
            (loadTypeQ == LT_LHU): loadVal = {16'd0, halfVal};
            default:               loadVal = readDataQ;
        endcase
    end

    assign wb_valid    = validQ;
    assign wb_regwrite = validQ && regWriteQ && (writeRegQ != '0);
    assign wb_reg      = writeRegQ;
    assign wb_data     = memToRegQ ? loadVal : resultQ;
    assign align_err   = alignErrQ;
    assign retired     = retiredQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load extraction, $0 suppression,
// misalignment, stall/flush priority, async reset and counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [31:0] ReadData;
    logic [31:0] Result;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        MemtoReg;
    logic [2:0]  LoadType;

    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        align_err;
    logic [31:0] retired;

    logic        wbValid4;
    logic        wbRegwrite4;
    logic [4:0]  wbReg4;
    logic [31:0] wbData4;
    logic        alignErr4;
    logic [3:0]  retired4;

    int total  = 0;
    int passed = 0;
    int expRet = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ReadData(ReadData), .Result(Result),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .LoadType(LoadType), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data),
        .align_err(align_err), .retired(retired)
    );

    mem_wb_stage #(.CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ReadData(ReadData), .Result(Result),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .LoadType(LoadType), .wb_valid(wbValid4),
        .wb_regwrite(wbRegwrite4), .wb_reg(wbReg4), .wb_data(wbData4),
        .align_err(alignErr4), .retired(retired4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One rising edge; bench-side retire count follows the capture rule.
    task automatic tick();
        @(posedge clk);
        if (valid_in && !stall && !flush) expRet++;
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [2:0] lt, input logic [31:0] res,
                         input logic [4:0] wr);
        valid_in = v;
        RegWrite = rw;
        MemtoReg = m2r;
        LoadType = lt;
        Result   = res;
        WriteReg = wr;
    endtask

    task automatic ld(input string tag, input logic [2:0] lt,
                      input logic [31:0] res, input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b1, lt, res, 5'd9);
        tick();
        chk(tag, wb_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ReadData = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_retired", retired, 32'd0);
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_00A5, 5'd8);
        tick();
        chk("alu_regwrite", {31'd0, wb_regwrite}, 32'd1);
        chk("alu_reg", {27'd0, wb_reg}, 32'd8);
        chk("alu_data", wb_data, 32'h0000_00A5);
        chk("alu_retired", retired, 32'd1);
        chk("alu_align", {31'd0, align_err}, 32'd0);

        ReadData = 32'h80FF_7F01;
        ld("lb_00",  3'b011, 32'h100, 32'hFFFF_FF80);
        ld("lbu_00", 3'b100, 32'h100, 32'h0000_0080);
        ld("lb_10",  3'b011, 32'h102, 32'h0000_007F);
        ld("lb_01",  3'b011, 32'h101, 32'hFFFF_FFFF);
        ld("lbu_11", 3'b100, 32'h103, 32'h0000_0001);
        ld("lh_00",  3'b001, 32'h100, 32'hFFFF_80FF);
        ld("lhu_10", 3'b010, 32'h102, 32'h0000_7F01);
        ld("lhu_00", 3'b010, 32'h100, 32'h0000_80FF);
        ld("lw",     3'b000, 32'h100, 32'h80FF_7F01);
        ld("lw_111", 3'b111, 32'h100, 32'h80FF_7F01);
        chk("lw_align", {31'd0, align_err}, 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h55, 5'd0);
        tick();
        chk("r0_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("r0_valid", {31'd0, wb_valid}, 32'd1);

        ld("lw_mis_data", 3'b000, 32'h1002, 32'h80FF_7F01);
        chk("lw_mis_align", {31'd0, align_err}, 32'd1);
        chk("lw_mis_we", {31'd0, wb_regwrite}, 32'd1);
        ld("lh_mis_data", 3'b001, 32'h1003, 32'h0000_7F01);
        chk("lh_mis_align", {31'd0, align_err}, 32'd1);
        ld("lb_odd", 3'b011, 32'h1003, 32'h0000_0001);
        chk("lb_odd_align", {31'd0, align_err}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'd0, 32'h1002, 5'd9);
        tick();
        chk("norw_align", {31'd0, align_err}, 32'd0);
        chk("norw_we", {31'd0, wb_regwrite}, 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_1234, 5'd5);
        tick();
        chk("a_data", wb_data, 32'h0000_1234);
        chk("a_retired", retired, expRet);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 3'd0, 32'hDEAD_0002 + i, 5'd6);
            tick();
            chk("stall_data", wb_data, 32'h0000_1234);
            chk("stall_reg", {27'd0, wb_reg}, 32'd5);
            chk("stall_retired", retired, expRet);
        end
        chk("stall_retired_abs", retired, 32'd17);
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_we", {31'd0, wb_regwrite}, 32'd0);
        chk("flush_align", {31'd0, align_err}, 32'd0);
        chk("flush_retired", retired, 32'd17);
        stall = 1'b0;
        tick();
        chk("flush_only_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_only_ret", retired, 32'd17);
        flush = 1'b0;

        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h77, 5'd8);
        tick();
        chk("pre_rst_we", {31'd0, wb_regwrite}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_we", {31'd0, wb_regwrite}, 32'd0);
        chk("async_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_reg", {27'd0, wb_reg}, 32'd0);
        chk("async_data", wb_data, 32'd0);
        chk("async_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) tick();
        chk("wrap_cnt4", {28'd0, retired4}, 32'd1);
        chk("wrap_cnt32", retired, 32'd17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
